// File: rtl/avalon_camera_mbuf_pkg.sv
// Camera register-file package: word addresses, camera_config reset
// defaults and small helpers shared by the avalon_camera_mbuf files.
package camera_regs_pkg;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_CAP_W    = 6'h01;
    localparam logic [5:0] ADDR_CAP_H    = 6'h02;
    localparam logic [5:0] ADDR_FULL     = 6'h03;
    localparam logic [5:0] ADDR_OVERRUN  = 6'h04;
    localparam logic [5:0] ADDR_STANDBY  = 6'h05;
    localparam logic [5:0] ADDR_LINE_CNT = 6'h06;
    localparam logic [5:0] ADDR_IRQ_MASK = 6'h07;
    localparam logic [5:0] ADDR_CFG_BASE = 6'h09;
    localparam logic [5:0] ADDR_BUFF_BASE = 6'h20;
    localparam logic [5:0] ADDR_SOFT_RST = 6'h3F;

    localparam int NUM_CFG = 9;

    localparam logic [15:0] DEF_WIDTH     = 16'd320;
    localparam logic [15:0] DEF_HEIGHT    = 16'd240;
    localparam logic [15:0] DEF_START_ROW = 16'h0036;
    localparam logic [15:0] DEF_START_COL = 16'h0010;
    localparam logic [15:0] DEF_ROW_SIZE  = 16'h059f;
    localparam logic [15:0] DEF_COL_SIZE  = 16'h077f;
    localparam logic [15:0] DEF_ROW_MODE  = 16'h0002;
    localparam logic [15:0] DEF_COL_MODE  = 16'h0002;
    localparam logic [15:0] DEF_EXPOSURE  = 16'h07c0;

    function automatic logic [3:0] popcount8(
        input logic [7:0] v
    );
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Expand Avalon byte enables to a 32-bit bit mask.
    function automatic logic [31:0] be_mask(
        input logic [3:0] be
    );
        return {{8{be[3]}}, {8{be[2]}},
                {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/avalon_camera_mbuf_if.sv
// Avalon-MM slave bundle for the camera register file.
// master: bus side (drives strobes); slave: register file side.
interface avalon_camera_mbuf_if;

    logic [5:0]  avs_s1_address;
    logic        avs_s1_read;
    logic        avs_s1_readdatavalid;
    logic [31:0] avs_s1_readdata;
    logic        avs_s1_write;
    logic [31:0] avs_s1_writedata;
    logic [3:0]  avs_s1_byteenable;
    logic        avs_s1_irq;

    modport master (
        output avs_s1_address,
        output avs_s1_read,
        output avs_s1_write,
        output avs_s1_writedata,
        output avs_s1_byteenable,
        input  avs_s1_readdatavalid,
        input  avs_s1_readdata,
        input  avs_s1_irq
    );

    modport slave (
        input  avs_s1_address,
        input  avs_s1_read,
        input  avs_s1_write,
        input  avs_s1_writedata,
        input  avs_s1_byteenable,
        output avs_s1_readdatavalid,
        output avs_s1_readdata,
        output avs_s1_irq
    );

endinterface

// File: rtl/avalon_camera_mbuf_flag_sync.sv
// cam_flag_sync: synchronises one buffer-full input, edge-detects it and
// keeps sticky FULL / OVERRUN bits with W1C clears (set beats clear).
module cam_flag_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    input  logic clr,
    input  logic clr_ovr,
    output logic set_pulse,
    output logic full,
    output logic overrun
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    logic full_q, full_d;
    logic ovr_q, ovr_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
        set_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
        full_d = (full_q & ~clr) | set_pulse;
        // A set that lands on a same-cycle clear is a fresh fill.
        ovr_d = (ovr_q & ~clr_ovr)
              | (set_pulse & full_q & ~clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            full_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            full_q <= full_d;
            ovr_q  <= ovr_d;
        end
    end

    assign full    = full_q;
    assign overrun = ovr_q;

endmodule

// File: rtl/avalon_camera_mbuf.sv
// Camera control register file (Avalon-MM slave) for NUM_BUFF line buffers.
// Ports: clk/reset_n, avs bus (slave modport), avs_export_* to capture/config.
// Optional interrupt: define CAMERA_IRQ_EN to build IRQ_MASK and avs_s1_irq.
module avalon_camera_mbuf
    import camera_regs_pkg::*;
#(
    parameter int          NUM_BUFF    = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] WIDTH       = DEF_WIDTH,
    parameter logic [15:0] HEIGHT      = DEF_HEIGHT,
    parameter logic [15:0] START_ROW   = DEF_START_ROW,
    parameter logic [15:0] START_COL   = DEF_START_COL,
    parameter logic [15:0] ROW_SIZE    = DEF_ROW_SIZE,
    parameter logic [15:0] COL_SIZE    = DEF_COL_SIZE,
    parameter logic [15:0] ROW_MODE    = DEF_ROW_MODE,
    parameter logic [15:0] COL_MODE    = DEF_COL_MODE,
    parameter logic [15:0] EXPOSURE    = DEF_EXPOSURE
) (
    input  logic                    clk,
    input  logic                    reset_n,
    avalon_camera_mbuf_if.slave     avs,
    output logic                    avs_export_start_capture,
    output logic [23:0]             avs_export_capture_width,
    output logic [23:0]             avs_export_capture_height,
    output logic [32*NUM_BUFF-1:0]  avs_export_buff,
    input  logic [NUM_BUFF-1:0]     avs_export_buff_full,
    input  logic                    avs_export_capture_standby,
    output logic [15:0]             avs_export_width,
    output logic [15:0]             avs_export_height,
    output logic [15:0]             avs_export_start_row,
    output logic [15:0]             avs_export_start_col,
    output logic [15:0]             avs_export_row_size,
    output logic [15:0]             avs_export_col_size,
    output logic [15:0]             avs_export_row_mode,
    output logic [15:0]             avs_export_col_mode,
    output logic [15:0]             avs_export_exposure,
    output logic                    avs_export_cam_soft_reset_n
);

    localparam logic [16*NUM_CFG-1:0] CFG_RST = {
        EXPOSURE, COL_MODE, ROW_MODE, COL_SIZE, ROW_SIZE,
        START_COL, START_ROW, HEIGHT, WIDTH
    };

    logic                          ctrl_q, ctrl_d;
    logic [23:0]                   cap_w_q, cap_w_d;
    logic [23:0]                   cap_h_q, cap_h_d;
    logic [NUM_CFG-1:0][15:0]      cfg_q, cfg_d;
    logic [NUM_BUFF-1:0][31:0]     buff_q, buff_d;
    logic                          soft_rst_q, soft_rst_d;
    logic [23:0]                   line_cnt_q, line_cnt_d;
    logic                          rdv_q, rdv_d;
    logic [31:0]                   rdata_q, rdata_d;

    logic [5:0]                    addr;
    logic                          wr_en;
    logic [3:0]                    be;
    logic [31:0]                   wdata;
    logic [31:0]                   bmask;
    logic [31:0]                   wmask;
    logic [NUM_BUFF-1:0]           set_pulse;
    logic [NUM_BUFF-1:0]           full_vec;
    logic [NUM_BUFF-1:0]           ovr_vec;
    logic [NUM_BUFF-1:0]           full_clr;
    logic [NUM_BUFF-1:0]           ovr_clr;
    logic [7:0]                    pulse8;
    logic [24:0]                   lc_sum;
    logic                          ctrl_rise;

    for (genvar i = 0; i < NUM_BUFF; i++) begin : g_flag
        cam_flag_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_flag (
            .clk       (clk),
            .reset_n   (reset_n),
            .async_in  (avs_export_buff_full[i]),
            .clr       (full_clr[i]),
            .clr_ovr   (ovr_clr[i]),
            .set_pulse (set_pulse[i]),
            .full      (full_vec[i]),
            .overrun   (ovr_vec[i])
        );
    end

    always_comb begin
        addr  = avs.avs_s1_address;
        wr_en = avs.avs_s1_write;
        be    = avs.avs_s1_byteenable;
        wdata = avs.avs_s1_writedata;
        bmask = be_mask(be);
        wmask = wdata & bmask;
        full_clr = '0;
        ovr_clr  = '0;
        if (wr_en && addr == ADDR_FULL) begin
            full_clr = wmask[NUM_BUFF-1:0];
        end
        if (wr_en && addr == ADDR_OVERRUN) begin
            ovr_clr = wmask[NUM_BUFF-1:0];
        end
    end

    // RW register writes with byte-lane merge.
    always_comb begin
        ctrl_d     = ctrl_q;
        cap_w_d    = cap_w_q;
        cap_h_d    = cap_h_q;
        cfg_d      = cfg_q;
        buff_d     = buff_q;
        soft_rst_d = soft_rst_q;
        if (wr_en) begin
            case (addr)
                ADDR_CTRL: begin
                    if (be[0]) ctrl_d = wdata[0];
                end
                ADDR_CAP_W: begin
                    cap_w_d = (cap_w_q & ~bmask[23:0])
                            | wmask[23:0];
                end
                ADDR_CAP_H: begin
                    cap_h_d = (cap_h_q & ~bmask[23:0])
                            | wmask[23:0];
                end
                ADDR_SOFT_RST: begin
                    if (be[0]) soft_rst_d = wdata[0];
                end
                default: ;
            endcase
            for (int k = 0; k < NUM_CFG; k++) begin
                if (addr == ADDR_CFG_BASE + 6'(k)) begin
                    cfg_d[k] = (cfg_q[k] & ~bmask[15:0])
                             | wmask[15:0];
                end
            end
            for (int i = 0; i < NUM_BUFF; i++) begin
                if (addr == ADDR_BUFF_BASE + 6'(i)) begin
                    buff_d[i] = (buff_q[i] & ~bmask) | wmask;
                end
            end
        end
    end

    // Line counter: adds this cycle's set pulses, saturates,
    // and a 0->1 write of CTRL[0] clears it over any pulses.
    always_comb begin
        ctrl_rise = wr_en && addr == ADDR_CTRL && be[0]
                 && wdata[0] && !ctrl_q;
        pulse8 = '0;
        pulse8[NUM_BUFF-1:0] = set_pulse;
        lc_sum = {1'b0, line_cnt_q}
               + {21'b0, popcount8(pulse8)};
        if (ctrl_rise) begin
            line_cnt_d = '0;
        end else if (lc_sum[24]) begin
            line_cnt_d = '1;
        end else begin
            line_cnt_d = lc_sum[23:0];
        end
    end

`ifdef CAMERA_IRQ_EN
    logic [NUM_BUFF:0] mask_q, mask_d;
    logic              irq_q, irq_d;

    always_comb begin
        mask_d = mask_q;
        if (wr_en && addr == ADDR_IRQ_MASK) begin
            mask_d = (mask_q & ~bmask[NUM_BUFF:0])
                   | wmask[NUM_BUFF:0];
        end
        irq_d = (|(full_vec & mask_q[NUM_BUFF-1:0]))
              | ((|ovr_vec) & mask_q[NUM_BUFF]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign avs.avs_s1_irq = irq_q;
`else
    assign avs.avs_s1_irq = 1'b0;
`endif

    // Read mux samples pre-write state, so a same-cycle
    // write never shows up in the returned word.
    always_comb begin
        rdv_d   = avs.avs_s1_read;
        rdata_d = rdata_q;
        if (avs.avs_s1_read) begin
            rdata_d = '0;
            case (addr)
                ADDR_CTRL:     rdata_d[0] = ctrl_q;
                ADDR_CAP_W:    rdata_d[23:0] = cap_w_q;
                ADDR_CAP_H:    rdata_d[23:0] = cap_h_q;
                ADDR_FULL:     rdata_d[NUM_BUFF-1:0] = full_vec;
                ADDR_OVERRUN:  rdata_d[NUM_BUFF-1:0] = ovr_vec;
                ADDR_STANDBY:
                    rdata_d[0] = avs_export_capture_standby;
                ADDR_LINE_CNT: rdata_d[23:0] = line_cnt_q;
`ifdef CAMERA_IRQ_EN
                ADDR_IRQ_MASK: rdata_d[NUM_BUFF:0] = mask_q;
`endif
                ADDR_SOFT_RST: rdata_d[0] = soft_rst_q;
                default: ;
            endcase
            for (int k = 0; k < NUM_CFG; k++) begin
                if (addr == ADDR_CFG_BASE + 6'(k)) begin
                    rdata_d[15:0] = cfg_q[k];
                end
            end
            for (int i = 0; i < NUM_BUFF; i++) begin
                if (addr == ADDR_BUFF_BASE + 6'(i)) begin
                    rdata_d = buff_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= 1'b0;
            cap_w_q    <= '0;
            cap_h_q    <= '0;
            cfg_q      <= CFG_RST;
            buff_q     <= '0;
            soft_rst_q <= 1'b1;
            line_cnt_q <= '0;
            rdv_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            cap_w_q    <= cap_w_d;
            cap_h_q    <= cap_h_d;
            cfg_q      <= cfg_d;
            buff_q     <= buff_d;
            soft_rst_q <= soft_rst_d;
            line_cnt_q <= line_cnt_d;
            rdv_q      <= rdv_d;
            rdata_q    <= rdata_d;
        end
    end

    assign avs.avs_s1_readdatavalid  = rdv_q;
    assign avs.avs_s1_readdata       = rdata_q;
    assign avs_export_start_capture  = ctrl_q;
    assign avs_export_capture_width  = cap_w_q;
    assign avs_export_capture_height = cap_h_q;
    assign avs_export_buff           = buff_q;
    assign avs_export_width          = cfg_q[0];
    assign avs_export_height         = cfg_q[1];
    assign avs_export_start_row      = cfg_q[2];
    assign avs_export_start_col      = cfg_q[3];
    assign avs_export_row_size       = cfg_q[4];
    assign avs_export_col_size       = cfg_q[5];
    assign avs_export_row_mode       = cfg_q[6];
    assign avs_export_col_mode       = cfg_q[7];
    assign avs_export_exposure       = cfg_q[8];
    assign avs_export_cam_soft_reset_n = soft_rst_q;

endmodule
